// File: rtl/dacspi_responder_if.sv
// SPI link between dacspi (master) and the LTC2624 responder (slave).
// Pin-level signals only; the system clock and reset stay outside.
interface dacspi_responder_if;
  logic SPI_SCK;
  logic SPI_MOSI;
  logic DAC_CS;
  logic DAC_CLR;
  logic DAC_OUT;

  modport master (output SPI_SCK, output SPI_MOSI, output DAC_CS, output DAC_CLR, input DAC_OUT);
  modport slave  (input SPI_SCK, input SPI_MOSI, input DAC_CS, input DAC_CLR, output DAC_OUT);
endinterface

// File: rtl/dacspi_responder.sv
// LTC2624 responder: decodes 32-bit SPI frames into 4 input/DAC registers and echoes the previous frame.
// Register updates and word_valid land 4 CLK50MHZ cycles after the CS rising edge; no backpressure.
module dacspi_responder #(
  parameter int WORD_BITS = 32,
  parameter int DATA_BITS = 12
) (
  input  logic                   CLK50MHZ,
  input  logic                   RST,
  dacspi_responder_if.slave      spi,
  output logic [4*DATA_BITS-1:0] dac_val,
  output logic [3:0]             pwrdn,
  output logic                   word_valid,
  output logic [WORD_BITS-1:0]   last_word,
  output logic                   frame_err
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] DECODE = 2'd2;
  localparam logic [5:0] WORD_CNT = 6'(WORD_BITS);

  logic [2:0] sck_q, cs_q;
  logic [1:0] mosi_q, clr_q;
  logic       sck_rise, sck_fall, cs_fall, cs_rise;

  logic [1:0]           state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [WORD_BITS-1:0] shreg_q, shreg_d;
  logic [WORD_BITS-1:0] echo_q, echo_d;
  logic [WORD_BITS-1:0] last_q, last_d;
  logic [DATA_BITS-1:0] inp_q [4];
  logic [DATA_BITS-1:0] inp_d [4];
  logic [DATA_BITS-1:0] dac_q [4];
  logic [DATA_BITS-1:0] dac_d [4];
  logic [3:0]           pwrdn_q, pwrdn_d;
  logic                 wv_q, wv_d, err_q, err_d;

  logic [3:0]           cmd, addr, sel;
  logic [DATA_BITS-1:0] data;

  // Index 2 is the previous synchronized sample, used only for edge detection
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];

  assign cmd  = shreg_q[23:20];
  assign addr = shreg_q[19:16];
  assign data = shreg_q[4 +: DATA_BITS];

  always_comb begin
    sel = 4'b0000;
    if (addr == 4'hF)     sel = 4'b1111;
    else if (addr < 4'd4) sel = 4'b0001 << addr[1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    echo_d  = echo_q;
    last_d  = last_q;
    inp_d   = inp_q;
    dac_d   = dac_q;
    pwrdn_d = pwrdn_q;
    wv_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = 6'd0;
          echo_d  = last_q;
        end
      end
      SHIFT: begin
        if (sck_rise) begin
          shreg_d = {shreg_q[WORD_BITS-2:0], mosi_q[1]};
          if (cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;
        end
        if (sck_fall) echo_d = {echo_q[WORD_BITS-2:0], 1'b0};
        if (cs_rise) begin
          if (cnt_q == WORD_CNT) begin
            state_d = DECODE;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      DECODE: begin
        state_d = IDLE;
        wv_d    = 1'b1;
        last_d  = shreg_q;
        for (int n = 0; n < 4; n++) begin
          if (sel[n]) begin
            case (cmd)
              4'h0, 4'h2: inp_d[n] = data;
              4'h1: begin
                dac_d[n]   = inp_q[n];
                pwrdn_d[n] = 1'b0;
              end
              4'h3: begin
                inp_d[n]   = data;
                dac_d[n]   = data;
                pwrdn_d[n] = 1'b0;
              end
              4'h4:    pwrdn_d[n] = 1'b1;
              default: ;
            endcase
          end
        end
        // Update-all uses the input bank including the value just written
        if (cmd == 4'h2 && sel != 4'b0000) begin
          for (int n = 0; n < 4; n++) dac_d[n] = inp_d[n];
          pwrdn_d = 4'b0000;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!clr_q[1]) begin
      for (int n = 0; n < 4; n++) begin
        inp_d[n] = '0;
        dac_d[n] = '0;
      end
    end
  end

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      sck_q   <= '0;
      cs_q    <= '0;
      mosi_q  <= '0;
      clr_q   <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      echo_q  <= '0;
      last_q  <= '0;
      pwrdn_q <= '0;
      wv_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        inp_q[n] <= '0;
        dac_q[n] <= '0;
      end
    end else begin
      sck_q   <= {sck_q[1:0], spi.SPI_SCK};
      cs_q    <= {cs_q[1:0], spi.DAC_CS};
      mosi_q  <= {mosi_q[0], spi.SPI_MOSI};
      clr_q   <= {clr_q[0], spi.DAC_CLR};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      echo_q  <= echo_d;
      last_q  <= last_d;
      pwrdn_q <= pwrdn_d;
      wv_q    <= wv_d;
      err_q   <= err_d;
      inp_q   <= inp_d;
      dac_q   <= dac_d;
    end
  end

  assign spi.DAC_OUT = (state_q == SHIFT) ? echo_q[WORD_BITS-1] : 1'b0;
  assign dac_val     = {dac_q[3], dac_q[2], dac_q[1], dac_q[0]};
  assign pwrdn       = pwrdn_q;
  assign word_valid  = wv_q;
  assign last_word   = last_q;
  assign frame_err   = err_q;
endmodule
